// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine-side job controller: gates the source stream into the kernel, buffers kernel
// results in a small FIFO toward the sink, and ends a job after cnt_limit output beats.
module multi_dataflow_engine_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  cnt_limit_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cnt_out_o,
  output logic [CNT_W-1:0]  cnt_in_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              k_in_valid_o,
  input  logic              k_in_ready_i,
  output logic [DATA_W-1:0] k_in_data_o,
  input  logic              k_out_valid_i,
  output logic              k_out_ready_o,
  input  logic [DATA_W-1:0] k_out_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
  logic [CNT_W-1:0]  cnt_in_q, cnt_in_d;
  logic              done_q, done_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic run, fifo_full, fifo_empty, start_acc;
  logic in_hs, push, pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A zero-limit job must see no handshakes at all, so the run gate also requires limit != 0.
  assign run        = enable_i & (state_q == RUN) & (limit_q != '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign start_acc  = start_i & ~clear_i & (state_q != RUN);

  assign k_in_valid_o  = run & in_valid_i;
  assign in_ready_o    = run & k_in_ready_i;
  assign k_in_data_o   = in_data_i;
  assign k_out_ready_o = run & ~fifo_full;
  assign out_valid_o   = run & ~fifo_empty;
  assign out_data_o    = out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign in_hs = in_valid_i & in_ready_o;
  assign push  = k_out_valid_i & k_out_ready_o;
  assign pop   = out_valid_o & out_ready_i;

  assign ready_o   = (state_q != RUN);
  assign done_o    = done_q;
  assign cnt_out_o = cnt_out_q;
  assign cnt_in_o  = cnt_in_q;

  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    cnt_out_d = cnt_out_q;
    cnt_in_d  = cnt_in_q;
    done_d    = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clear_i) begin
      state_d   = IDLE;
      limit_d   = '0;
      cnt_out_d = '0;
      cnt_in_d  = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else if (start_acc) begin
      state_d   = RUN;
      limit_d   = cnt_limit_i;
      cnt_out_d = '0;
      cnt_in_d  = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else if (state_q == RUN) begin
      if (limit_q == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        if (in_hs) cnt_in_d = sat_inc(cnt_in_q);
        if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + AW'(1);
          cnt_out_d = cnt_out_q + CNT_W'(1);
          if (cnt_out_d == limit_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        case ({push, pop})
          2'b10:   count_d = count_q + (AW+1)'(1);
          2'b01:   count_d = count_q - (AW+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      cnt_out_q <= '0;
      cnt_in_q  <= '0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      cnt_out_q <= cnt_out_d;
      cnt_in_q  <= cnt_in_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage carries data only; occupancy is tracked by the reset pointers above.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= k_out_data_i;
  end

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// Directed bench for multi_dataflow_engine_ctrl with an identity kernel, an
// incrementing-word source and a recording sink.
module tb_multi_dataflow_engine_ctrl;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              clear_i = 1'b0;
  logic              enable_i = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  cnt_limit_i = '0;
  logic              ready_o, done_o;
  logic [CNT_W-1:0]  cnt_out_o, cnt_in_o;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              k_in_valid_o, k_in_ready_i;
  logic [DATA_W-1:0] k_in_data_o;
  logic              k_out_valid_i, k_out_ready_o;
  logic [DATA_W-1:0] k_out_data_i;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [DATA_W-1:0] out_data_o;

  multi_dataflow_engine_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .start_i(start_i), .cnt_limit_i(cnt_limit_i), .ready_o(ready_o), .done_o(done_o),
    .cnt_out_o(cnt_out_o), .cnt_in_o(cnt_in_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .k_in_valid_o(k_in_valid_o), .k_in_ready_i(k_in_ready_i), .k_in_data_o(k_in_data_o),
    .k_out_valid_i(k_out_valid_i), .k_out_ready_o(k_out_ready_o), .k_out_data_i(k_out_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
  );

  always #5 clk_i = ~clk_i;

  // identity kernel
  assign k_in_ready_i  = k_out_ready_o;
  assign k_out_valid_i = k_in_valid_o;
  assign k_out_data_i  = k_in_data_o;

  logic [DATA_W-1:0] src_q = 32'h100;
  int in_hs_n = 0, push_n = 0, pop_n = 0, done_n = 0;
  logic [DATA_W-1:0] sink_q[$];

  assign in_data_i = src_q;

  always @(posedge clk_i) begin
    if (in_valid_i && in_ready_o) begin
      src_q   <= src_q + 32'd1;
      in_hs_n <= in_hs_n + 1;
    end
    if (k_out_valid_i && k_out_ready_o) push_n <= push_n + 1;
    if (out_valid_o && out_ready_i) begin
      pop_n <= pop_n + 1;
      sink_q.push_back(out_data_o);
    end
    if (done_o) done_n <= done_n + 1;
  end

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [CNT_W-1:0] lim);
    start_i     = 1'b1;
    cnt_limit_i = lim;
    @(negedge clk_i);
    start_i     = 1'b0;
  endtask

  task automatic wait_cnt(input logic [CNT_W-1:0] target, input int budget);
    logic [CNT_W-1:0] prev;
    int n;
    prev = cnt_out_o;
    n = 0;
    while (cnt_out_o !== target && n < budget) begin
      @(negedge clk_i);
      n++;
      if (cnt_out_o !== prev) begin
        check_eq("cnt_step", 32'(cnt_out_o), 32'(prev) + 32'd1);
        prev = cnt_out_o;
      end
    end
    if (cnt_out_o !== target) check_eq("cnt_timeout", 32'(cnt_out_o), 32'(target));
  endtask

  task automatic check_words(input int first, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (first + i < sink_q.size()) check_eq("word", sink_q[first+i], base + 32'(i));
      else check_eq("word_missing", 32'd0, 32'd1);
    end
  endtask

  initial begin
    int s, d0, h0, p0, q0;
    logic [31:0] base;

    // reset
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_cnt_out", 32'(cnt_out_o), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready_o), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);

    // job of 4 beats with sink always ready
    enable_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    s = sink_q.size(); d0 = done_n; p0 = pop_n;
    start_job(16'd4);
    wait_cnt(16'd4, 30);
    check_eq("j1_done", 32'(done_o), 32'd1);
    check_eq("j1_ready", 32'(ready_o), 32'd1);
    check_eq("j1_in_ready", 32'(in_ready_o), 32'd0);
    check_eq("j1_cnt_in", 32'(cnt_in_o), 32'd5);
    @(negedge clk_i);
    check_eq("j1_done_pulse", 32'(done_o), 32'd0);
    check_eq("j1_done_n", 32'(done_n - d0), 32'd1);
    check_eq("j1_pops", 32'(pop_n - p0), 32'd4);
    check_words(s, 32'h100, 4);

    // FIFO fill with sink stalled, then drain
    out_ready_i = 1'b0;
    s = sink_q.size(); d0 = done_n; h0 = push_n;
    start_job(16'd4);
    for (int i = 0; i < 20 && k_out_ready_o !== 1'b0; i++) @(negedge clk_i);
    check_eq("fill_pushes", 32'(push_n - h0), 32'd4);
    repeat (2) @(negedge clk_i);
    check_eq("fill_k_out_ready", 32'(k_out_ready_o), 32'd0);
    check_eq("fill_out_valid", 32'(out_valid_o), 32'd1);
    check_eq("fill_cnt_out", 32'(cnt_out_o), 32'd0);
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      check_eq("drain_cnt", 32'(cnt_out_o), 32'(i));
    end
    check_eq("drain_done", 32'(done_o), 32'd1);
    check_words(s, 32'h105, 4);
    @(negedge clk_i);
    check_eq("drain_done_n", 32'(done_n - d0), 32'd1);

    // enable low for 3 cycles at cnt_out=2
    s = sink_q.size(); base = src_q; d0 = done_n;
    start_job(16'd4);
    wait_cnt(16'd2, 20);
    enable_i = 1'b0;
    h0 = in_hs_n; p0 = pop_n; q0 = push_n;
    #1;
    check_eq("pause_in_ready", 32'(in_ready_o), 32'd0);
    check_eq("pause_k_in_valid", 32'(k_in_valid_o), 32'd0);
    check_eq("pause_k_out_ready", 32'(k_out_ready_o), 32'd0);
    check_eq("pause_out_valid", 32'(out_valid_o), 32'd0);
    repeat (3) @(negedge clk_i);
    check_eq("pause_cnt_out", 32'(cnt_out_o), 32'd2);
    check_eq("pause_cnt_in", 32'(cnt_in_o), 32'd3);
    check_eq("pause_hs", 32'((in_hs_n - h0) + (pop_n - p0) + (push_n - q0)), 32'd0);
    enable_i = 1'b1;
    wait_cnt(16'd4, 20);
    check_eq("resume_done", 32'(done_o), 32'd1);
    check_words(s, base, 4);
    @(negedge clk_i);
    check_eq("resume_done_n", 32'(done_n - d0), 32'd1);

    // clear (with start in the same cycle) at cnt_out=2
    start_job(16'd4);
    wait_cnt(16'd2, 20);
    d0 = done_n;
    clear_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0; start_i = 1'b0;
    check_eq("clr_ready", 32'(ready_o), 32'd1);
    check_eq("clr_cnt_out", 32'(cnt_out_o), 32'd0);
    check_eq("clr_cnt_in", 32'(cnt_in_o), 32'd0);
    check_eq("clr_out_valid", 32'(out_valid_o), 32'd0);
    check_eq("clr_in_ready", 32'(in_ready_o), 32'd0);
    repeat (3) @(negedge clk_i);
    check_eq("clr_no_done", 32'(done_n - d0), 32'd0);
    check_eq("clr_stays_idle", 32'(ready_o), 32'd1);
    check_eq("clr_stays_zero", 32'(cnt_out_o), 32'd0);

    // zero-limit job, then restart with limit 2
    h0 = in_hs_n; p0 = pop_n;
    start_job(16'd0);
    check_eq("z_run_ready", 32'(ready_o), 32'd0);
    check_eq("z_run_done", 32'(done_o), 32'd0);
    check_eq("z_in_ready", 32'(in_ready_o), 32'd0);
    @(negedge clk_i);
    check_eq("z_done", 32'(done_o), 32'd1);
    check_eq("z_ready", 32'(ready_o), 32'd1);
    check_eq("z_no_hs", 32'((in_hs_n - h0) + (pop_n - p0)), 32'd0);
    @(negedge clk_i);
    check_eq("z_done_pulse", 32'(done_o), 32'd0);
    s = sink_q.size(); base = src_q;
    start_job(16'd2);
    wait_cnt(16'd2, 20);
    check_eq("z2_done", 32'(done_o), 32'd1);
    check_words(s, base, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
